// File: rtl/m_mem_master.sv
// Data-memory initiator: takes one load/store at a time from the MEM stage, validates it,
// holds the memory signals for LAT cycles and returns a single response pulse.
module m_mem_master #(
    parameter int MEM_BYTES = 4096,
    parameter int LAT       = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_mode,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_exc,
    output logic        busy,
    output logic        MEMwrite,
    output logic        MEMread,
    output logic [31:0] MEMmode,
    output logic [31:0] addr,
    output logic [31:0] data,
    output logic [31:0] PC,
    input  logic [31:0] mem_out
);
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          first_reg;
    logic          we_reg;
    logic          uns_reg;
    logic [1:0]    mode_reg;
    logic [31:0]   addr_reg;
    logic [31:0]   wdata_reg;
    logic [31:0]   pc_reg;
    logic [31:0]   rdata_reg;
    logic          exc_reg;

    logic          accept;
    logic          req_err;
    logic          in_access;
    logic          last_access;
    logic [2:0]    size;
    logic [32:0]   end_addr;
    logic [31:0]   load_result;

    assign accept      = (state_reg == IDLE) && req_valid;
    assign in_access   = (state_reg == ACCESS);
    assign last_access = in_access && (cnt_reg == '0);

    always_comb begin
        size = 3'd0;
        case (req_mode)
            2'd0:    size = 3'd4;
            2'd1:    size = 3'd1;
            2'd2:    size = 3'd2;
            default: size = 3'd0;
        endcase
    end

    // 33-bit sum so an access straddling 2^32 cannot wrap back into range
    assign end_addr = {1'b0, req_addr} + {30'b0, size};
    assign req_err  = (req_mode == 2'd3)
                   || ((req_mode == 2'd0) && (req_addr[1:0] != 2'b00))
                   || ((req_mode == 2'd2) && req_addr[0])
                   || (end_addr > 33'(MEM_BYTES));

    // Memory already sign-extends byte/half; only the unsigned case needs masking
    always_comb begin
        load_result = mem_out;
        case (mode_reg)
            2'd1:    if (uns_reg) load_result = {24'b0, mem_out[7:0]};
            2'd2:    if (uns_reg) load_result = {16'b0, mem_out[15:0]};
            default: load_result = mem_out;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    state_next = req_err ? RESP : ACCESS;
                    cnt_next   = CW'(LAT - 1);
                end
            end
            ACCESS: begin
                if (cnt_reg == '0) state_next = RESP;
                else               cnt_next   = cnt_reg - CW'(1);
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            first_reg <= 1'b0;
            we_reg    <= 1'b0;
            uns_reg   <= 1'b0;
            mode_reg  <= 2'd0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            pc_reg    <= '0;
            rdata_reg <= '0;
            exc_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            first_reg <= accept && !req_err;
            if (accept) begin
                we_reg    <= req_we;
                uns_reg   <= req_unsigned;
                mode_reg  <= req_mode;
                addr_reg  <= req_addr;
                wdata_reg <= req_wdata;
                pc_reg    <= req_pc;
                if (req_err) begin
                    rdata_reg <= '0;
                    exc_reg   <= 1'b1;
                end
            end
            if (last_access) begin
                rdata_reg <= we_reg ? 32'd0 : load_result;
                exc_reg   <= 1'b0;
            end
        end
    end

    assign req_ready = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign rsp_valid = (state_reg == RESP);
    assign rsp_rdata = rdata_reg;
    assign rsp_exc   = exc_reg;

    // Strobes are gated by reset so an aborted access cannot touch memory
    assign MEMwrite  = in_access && first_reg && we_reg && !reset;
    assign MEMread   = in_access && !we_reg && !reset;
    assign MEMmode   = in_access ? {30'b0, mode_reg} : 32'd0;
    assign addr      = in_access ? addr_reg  : 32'd0;
    assign data      = in_access ? wdata_reg : 32'd0;
    assign PC        = in_access ? pc_reg    : 32'd0;
endmodule

// File: tb/tb_m_mem_master.sv
// Scoreboard bench for m_mem_master: two instances (LAT=1 and LAT=3) against a byte-array
// reference memory; a per-instance monitor pops expected responses as the DUT produces them.
module tb_m_mem_master;
    localparam int MEMB = 4096;

    typedef struct {
        int          inst;
        logic [31:0] rdata;
        logic        exc;
        int          acc_cyc;
        int          lat;
        logic        we;
        logic [1:0]  mode;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] pc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic        reset[2], req_valid[2], req_ready[2], req_we[2], req_unsigned[2];
    logic        rsp_valid[2], rsp_exc[2], busy[2], MEMwrite[2], MEMread[2];
    logic [1:0]  req_mode[2];
    logic [31:0] req_addr[2], req_wdata[2], req_pc[2], rsp_rdata[2];
    logic [31:0] MEMmode[2], addr[2], data[2], PC[2];

    logic [7:0] ref_mem [2][MEMB];
    exp_t       exp_q[$];

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // Reference behaviour: little-endian byte array, rules taken directly from the request semantics
    function automatic void model(input int inst, input logic we, input logic [1:0] mode,
                                  input logic uns, input logic [31:0] a, input logic [31:0] wd,
                                  output logic exc, output logic [31:0] rdata);
        int size;
        longint v;
        size  = (mode == 2'd0) ? 4 : (mode == 2'd1) ? 1 : (mode == 2'd2) ? 2 : 0;
        exc   = (mode == 2'd3) || (mode == 2'd0 && (a % 4) != 0) || (mode == 2'd2 && (a % 2) != 0)
             || (longint'(a) + size > MEMB);
        rdata = 32'd0;
        if (exc) return;
        if (we) begin
            for (int i = 0; i < size; i++) ref_mem[inst][a + i] = wd[8*i +: 8];
            return;
        end
        v = 0;
        for (int i = 0; i < size; i++) v = v + (longint'(ref_mem[inst][a + i]) << (8 * i));
        if (!uns && size == 1 && v >= 128)   v = v - 256;
        if (!uns && size == 2 && v >= 32768) v = v - 65536;
        rdata = v[31:0];
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_inst
            logic [31:0] mout;
            logic [7:0]  emem [MEMB];
            logic        init_done = 1'b0;
            logic [11:0] a0;
            logic [31:0] wv;
            int          wr_cnt = 0;
            int          rd_cnt = 0;
            int          busy_cnt = 0;

            m_mem_master #(.MEM_BYTES(MEMB), .LAT(gi == 0 ? 1 : 3)) dut (
                .clk(clk), .reset(reset[gi]),
                .req_valid(req_valid[gi]), .req_ready(req_ready[gi]), .req_we(req_we[gi]),
                .req_mode(req_mode[gi]), .req_unsigned(req_unsigned[gi]), .req_addr(req_addr[gi]),
                .req_wdata(req_wdata[gi]), .req_pc(req_pc[gi]),
                .rsp_valid(rsp_valid[gi]), .rsp_rdata(rsp_rdata[gi]), .rsp_exc(rsp_exc[gi]),
                .busy(busy[gi]), .MEMwrite(MEMwrite[gi]), .MEMread(MEMread[gi]),
                .MEMmode(MEMmode[gi]), .addr(addr[gi]), .data(data[gi]), .PC(PC[gi]),
                .mem_out(mout)
            );

            // Attached data memory: same initial image as the reference
            assign a0 = addr[gi][11:0];
            assign wv = {emem[a0 + 12'd3], emem[a0 + 12'd2], emem[a0 + 12'd1], emem[a0]};
            always_comb begin
                mout = 32'hDEADBEEF;
                if (MEMread[gi]) begin
                    case (MEMmode[gi])
                        32'd0:   mout = wv;
                        32'd1:   mout = {{24{wv[7]}}, wv[7:0]};
                        32'd2:   mout = {{16{wv[15]}}, wv[15:0]};
                        default: mout = 32'hDEADBEEF;
                    endcase
                end
            end
            always @(posedge clk) begin
                if (!init_done) begin
                    for (int i = 0; i < MEMB; i++) emem[i] = ref_mem[gi][i];
                    init_done = 1'b1;
                end else if (MEMwrite[gi]) begin
                    case (MEMmode[gi])
                        32'd0: for (int i = 0; i < 4; i++) emem[a0 + 12'(i)] = data[gi][8*i +: 8];
                        32'd1: emem[a0] = data[gi][7:0];
                        32'd2: for (int i = 0; i < 2; i++) emem[a0 + 12'(i)] = data[gi][8*i +: 8];
                        default: ;
                    endcase
                end
            end

            // Monitor
            always @(negedge clk) begin
                if (reset[gi]) begin
                    chk($sformatf("i%0d_rst_memwrite", gi), MEMwrite[gi], 0);
                    chk($sformatf("i%0d_rst_memread", gi), MEMread[gi], 0);
                    wr_cnt   <= 0;
                    rd_cnt   <= 0;
                    busy_cnt <= 0;
                end else begin
                    chk($sformatf("i%0d_busy_vs_ready", gi), busy[gi], !req_ready[gi]);
                    if ((MEMwrite[gi] || MEMread[gi]) && exp_q.size() > 0 && exp_q[0].inst == gi) begin
                        chk($sformatf("i%0d_addr", gi), addr[gi], exp_q[0].a);
                        chk($sformatf("i%0d_memmode", gi), MEMmode[gi], {30'b0, exp_q[0].mode});
                        chk($sformatf("i%0d_pc", gi), PC[gi], exp_q[0].pc);
                        if (MEMwrite[gi]) chk($sformatf("i%0d_data", gi), data[gi], exp_q[0].wd);
                    end
                    if (rsp_valid[gi]) begin
                        if (exp_q.size() == 0 || exp_q[0].inst != gi) begin
                            checks++;
                            errors++;
                            $display("FAIL i%0d_unexpected_rsp actual=rsp_valid required=none", gi);
                        end else begin
                            $display("i%0d rsp we=%0d mode=%0d addr=0x%08h rdata=0x%08h exc=%0d",
                                     gi, exp_q[0].we, exp_q[0].mode, exp_q[0].a, rsp_rdata[gi], rsp_exc[gi]);
                            chk($sformatf("i%0d_rdata", gi), rsp_rdata[gi], exp_q[0].rdata);
                            chk($sformatf("i%0d_exc", gi), rsp_exc[gi], exp_q[0].exc);
                            chk($sformatf("i%0d_latency", gi), cyc - exp_q[0].acc_cyc, exp_q[0].lat);
                            chk($sformatf("i%0d_ready_low_cycles", gi), busy_cnt + 1, exp_q[0].lat + 1);
                            chk($sformatf("i%0d_write_pulses", gi), wr_cnt,
                                (exp_q[0].we && !exp_q[0].exc) ? 1 : 0);
                            chk($sformatf("i%0d_read_cycles", gi), rd_cnt,
                                (!exp_q[0].we && !exp_q[0].exc) ? lat_of(gi) : 0);
                            exp_q.delete(0);
                        end
                        wr_cnt   <= 0;
                        rd_cnt   <= 0;
                        busy_cnt <= 0;
                    end else begin
                        wr_cnt   <= wr_cnt + (MEMwrite[gi] ? 1 : 0);
                        rd_cnt   <= rd_cnt + (MEMread[gi] ? 1 : 0);
                        busy_cnt <= busy_cnt + (req_ready[gi] ? 0 : 1);
                    end
                end
            end
        end
    endgenerate

    task automatic check_idle(input int inst, input string tag);
        chk($sformatf("i%0d_%s_ready", inst, tag), req_ready[inst], 1);
        chk($sformatf("i%0d_%s_busy", inst, tag), busy[inst], 0);
        chk($sformatf("i%0d_%s_rsp_valid", inst, tag), rsp_valid[inst], 0);
        chk($sformatf("i%0d_%s_rsp_rdata", inst, tag), rsp_rdata[inst], 0);
        chk($sformatf("i%0d_%s_rsp_exc", inst, tag), rsp_exc[inst], 0);
        chk($sformatf("i%0d_%s_memwrite", inst, tag), MEMwrite[inst], 0);
        chk($sformatf("i%0d_%s_memread", inst, tag), MEMread[inst], 0);
        chk($sformatf("i%0d_%s_memmode", inst, tag), MEMmode[inst], 0);
        chk($sformatf("i%0d_%s_addr", inst, tag), addr[inst], 0);
        chk($sformatf("i%0d_%s_data", inst, tag), data[inst], 0);
        chk($sformatf("i%0d_%s_pc", inst, tag), PC[inst], 0);
    endtask

    // Present one request; a junk req_valid follows while busy and must be ignored
    task automatic issue(input int inst, input logic we, input logic [1:0] mode, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd, input bit track);
        int budget;
        exp_t e;
        budget = 0;
        @(negedge clk);
        while (!req_ready[inst] && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 100) begin
            checks++;
            errors++;
            $display("FAIL i%0d_ready_timeout actual=0 required=1", inst);
            return;
        end
        e.inst    = inst;
        e.we      = we;
        e.mode    = mode;
        e.a       = a;
        e.wd      = wd;
        e.pc      = $urandom;
        e.acc_cyc = cyc + 1;
        model(inst, we, mode, uns, a, wd, e.exc, e.rdata);
        e.lat     = e.exc ? 0 : lat_of(inst);
        req_valid[inst]    = 1'b1;
        req_we[inst]       = we;
        req_mode[inst]     = mode;
        req_unsigned[inst] = uns;
        req_addr[inst]     = a;
        req_wdata[inst]    = wd;
        req_pc[inst]       = e.pc;
        if (track) exp_q.push_back(e);
        @(posedge clk);
        #1;
        req_we[inst]    = $urandom_range(0, 1);
        req_mode[inst]  = 2'($urandom_range(0, 2));
        req_addr[inst]  = 32'($urandom_range(0, 63)) & 32'hFFFF_FFFC;
        req_wdata[inst] = $urandom;
        @(posedge clk);
        #1;
        req_valid[inst] = 1'b0;
    endtask

    task automatic random_run(input int inst, input int n);
        logic [1:0]  mode;
        logic [31:0] a;
        int          r;
        for (int k = 0; k < n; k++) begin
            r    = $urandom_range(0, 7);
            mode = (r == 7) ? 2'd3 : 2'(r % 3);
            case ($urandom_range(0, 3))
                0, 1:    a = 32'($urandom_range(0, 63));
                2:       a = 32'($urandom_range(MEMB - 8, MEMB + 4));
                default: a = 32'($urandom_range(0, MEMB - 1));
            endcase
            issue(inst, 1'($urandom_range(0, 1)), mode, 1'($urandom_range(0, 1)), a, $urandom, 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        int budget;
        for (int i = 0; i < 2; i++) begin
            reset[i] = 1'b1; req_valid[i] = 1'b0; req_we[i] = 1'b0; req_mode[i] = 2'd0;
            req_unsigned[i] = 1'b0; req_addr[i] = '0; req_wdata[i] = '0; req_pc[i] = '0;
            for (int j = 0; j < MEMB; j++) ref_mem[i][j] = 8'($urandom);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle(0, "reset");
        check_idle(1, "reset");
        reset[0] = 1'b0;
        reset[1] = 1'b0;

        // LAT=1 directed
        issue(0, 1, 2'd0, 0, 32'h10, 32'h12345678, 1);
        issue(0, 0, 2'd0, 0, 32'h10, 32'h0, 1);
        issue(0, 1, 2'd1, 0, 32'h20, 32'h0, 1);
        issue(0, 1, 2'd1, 0, 32'h21, 32'h80, 1);
        issue(0, 0, 2'd1, 0, 32'h21, 32'h0, 1);
        issue(0, 0, 2'd1, 1, 32'h21, 32'h0, 1);
        issue(0, 0, 2'd2, 1, 32'h20, 32'h0, 1);
        issue(0, 0, 2'd2, 0, 32'h20, 32'h0, 1);
        issue(0, 0, 2'd2, 0, 32'h3, 32'h0, 1);
        issue(0, 0, 2'd3, 0, 32'h40, 32'h0, 1);
        issue(0, 1, 2'd3, 0, 32'h44, 32'h55, 1);
        issue(0, 0, 2'd0, 0, 32'hFFC, 32'h0, 1);
        issue(0, 0, 2'd0, 0, 32'hFFE, 32'h0, 1);
        issue(0, 1, 2'd0, 0, 32'hFFE, 32'hAAAA5555, 1);
        issue(0, 0, 2'd1, 0, 32'h1000, 32'h0, 1);
        issue(0, 0, 2'd1, 1, 32'hFFF, 32'h0, 1);
        issue(0, 1, 2'd2, 0, 32'hFFE, 32'hBEEF, 1);
        issue(0, 0, 2'd2, 0, 32'hFFE, 32'h0, 1);
        random_run(0, 60);

        // LAT=3 directed
        issue(1, 1, 2'd0, 0, 32'h100, 32'h0BADF00D, 1);
        issue(1, 0, 2'd0, 0, 32'h100, 32'h0, 1);
        issue(1, 0, 2'd2, 0, 32'h101, 32'h0, 1);

        // Reset during a store's ACCESS after its write: dropped, but the write stands
        issue(1, 1, 2'd0, 0, 32'h200, 32'hCAFEF00D, 0);
        @(negedge clk);
        reset[1] = 1'b1;
        @(negedge clk);
        check_idle(1, "rst_mid_store");
        reset[1] = 1'b0;
        issue(1, 0, 2'd0, 0, 32'h200, 32'h0, 1);

        // Reset during a load's ACCESS: MEMread must drop with reset
        issue(1, 0, 2'd0, 0, 32'h204, 32'h0, 0);
        @(negedge clk);
        reset[1] = 1'b1;
        @(negedge clk);
        check_idle(1, "rst_mid_load");
        reset[1] = 1'b0;

        // Reset and req_valid together: reset wins
        @(negedge clk);
        reset[1] = 1'b1;
        req_valid[1] = 1'b1; req_we[1] = 1'b0; req_mode[1] = 2'd0; req_addr[1] = 32'h10;
        @(negedge clk);
        reset[1] = 1'b0;
        req_valid[1] = 1'b0;
        @(negedge clk);
        check_idle(1, "rst_with_req");
        random_run(1, 40);

        budget = 0;
        while (exp_q.size() != 0 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        chk("drain_outstanding", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
